// File: rtl/sha512_dist_pkg.sv
// Shared widths, thread-number field extraction and FSM state type for the
// core input distributor.
package sha512_dist_pkg;

  localparam int unsigned DEF_N_CORES       = 3;
  localparam int unsigned DEF_N_CTX         = 2;
  localparam int unsigned DEF_N_SEQ         = 2;
  localparam int unsigned DEF_WORDS_PER_BLK = 16;
  localparam int unsigned DEF_DATA_WIDTH    = 64;
  localparam int unsigned DEF_BLK_OP_WIDTH  = 3;

  // A single core still gets a 1-bit core field in the thread number
  function automatic int unsigned core_w_of(input int unsigned n_cores);
    return (n_cores > 1) ? int'($clog2(n_cores)) : 1;
  endfunction

  localparam int unsigned DEF_CORE_W   = core_w_of(DEF_N_CORES);
  localparam int unsigned DEF_CTX_W    = $clog2(DEF_N_CTX);
  localparam int unsigned DEF_SEQ_W    = $clog2(DEF_N_SEQ);
  localparam int unsigned DEF_THREAD_W = DEF_CORE_W + DEF_CTX_W + DEF_SEQ_W;
  localparam int unsigned DEF_ADDR_W   = $clog2(DEF_WORDS_PER_BLK);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } dist_state_e;

  // Thread number is packed {core, ctx, seq}, seq in the LSBs
  function automatic logic [31:0] core_of(input logic [31:0] thr,
                                          input int unsigned ctx_w,
                                          input int unsigned seq_w);
    return thr >> (ctx_w + seq_w);
  endfunction

  function automatic logic [31:0] ctx_of(input logic [31:0] thr,
                                         input int unsigned ctx_w,
                                         input int unsigned seq_w);
    return (thr >> seq_w) & ((32'd1 << ctx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] seq_of(input logic [31:0] thr,
                                         input int unsigned seq_w);
    return thr & ((32'd1 << seq_w) - 32'd1);
  endfunction

endpackage

// File: rtl/core_input_dist_blk_word_counter.sv
// Word index inside the block being loaded, with first/last-word flags.
module blk_word_counter #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              first_c,
  output logic              last_c
);

  // Wraps to zero after the last word of a block
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) count <= '0;
    else if (inc) count <= count + ADDR_W'(1);
  end

  assign first_c = (count == '0);
  assign last_c  = &count;

endmodule

// File: rtl/core_input_dist.sv
// Routes a thread-tagged block word stream from realign to one of N_CORES
// SHA-512 cores, one block at a time, with handshake and completion pulses.
module core_input_dist
  import sha512_dist_pkg::*;
#(
  parameter  int unsigned N_CORES       = DEF_N_CORES,
  parameter  int unsigned N_CTX         = DEF_N_CTX,
  parameter  int unsigned N_SEQ         = DEF_N_SEQ,
  parameter  int unsigned WORDS_PER_BLK = DEF_WORDS_PER_BLK,
  parameter  int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter  int unsigned BLK_OP_WIDTH  = DEF_BLK_OP_WIDTH,
  localparam int unsigned CORE_W        = core_w_of(N_CORES),
  localparam int unsigned CTX_W         = $clog2(N_CTX),
  localparam int unsigned SEQ_W         = $clog2(N_SEQ),
  localparam int unsigned THREAD_W      = CORE_W + CTX_W + SEQ_W,
  localparam int unsigned ADDR_W        = $clog2(WORDS_PER_BLK)
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [THREAD_W-1:0]     in_thread_num,
  input  logic [BLK_OP_WIDTH-1:0] in_blk_op,
  input  logic [N_CORES-1:0]      core_ready,
  output logic [N_CORES-1:0]      core_wr_en,
  output logic [ADDR_W-1:0]       core_wr_addr,
  output logic [DATA_WIDTH-1:0]   core_din,
  output logic [BLK_OP_WIDTH-1:0] core_blk_op,
  output logic [CTX_W-1:0]        core_input_ctx,
  output logic [SEQ_W-1:0]        core_input_seq,
  output logic [N_CORES-1:0]      core_blk_done,
  output logic                    err_thread
);

  dist_state_e         state_q, state_d;
  logic [THREAD_W-1:0] thread_q;
  logic [CORE_W-1:0]   core_q, in_core, tgt_core;
  logic [CTX_W-1:0]    in_ctx;
  logic [SEQ_W-1:0]    in_seq;
  logic [N_CORES-1:0]  tgt_onehot;
  logic [ADDR_W-1:0]   word_idx;
  logic                cnt_first, cnt_last;
  logic                core_sel_rdy, accept, last_wr_q;

  assign in_core = CORE_W'(core_of(32'(in_thread_num), CTX_W, SEQ_W));
  assign in_ctx  = CTX_W'(ctx_of(32'(in_thread_num), CTX_W, SEQ_W));
  assign in_seq  = SEQ_W'(seq_of(32'(in_thread_num), SEQ_W));

  // Core fields beyond N_CORES-1 never match, so they read as not ready
  always_comb begin
    core_sel_rdy = 1'b0;
    for (int i = 0; i < int'(N_CORES); i++)
      if (in_core == CORE_W'(i)) core_sel_rdy = core_ready[i];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = RESET_N & core_sel_rdy;
        if (in_valid && RESET_N && core_sel_rdy) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = RESET_N;
        if (in_valid && cnt_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign tgt_core = (state_q == ST_IDLE) ? in_core : core_q;

  always_comb begin
    tgt_onehot = '0;
    for (int i = 0; i < int'(N_CORES); i++)
      tgt_onehot[i] = (tgt_core == CORE_W'(i));
  end

  blk_word_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc     (accept),
    .count   (word_idx),
    .first_c (cnt_first),
    .last_c  (cnt_last)
  );

  // Write port, block fields, done pulse and sticky thread error
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      thread_q       <= '0;
      core_q         <= '0;
      last_wr_q      <= 1'b0;
      core_wr_en     <= '0;
      core_wr_addr   <= '0;
      core_din       <= '0;
      core_blk_op    <= '0;
      core_input_ctx <= '0;
      core_input_seq <= '0;
      core_blk_done  <= '0;
      err_thread     <= 1'b0;
    end else begin
      core_wr_en    <= accept ? tgt_onehot : '0;
      last_wr_q     <= accept & cnt_last;
      core_blk_done <= last_wr_q ? core_wr_en : '0;
      if (accept) begin
        core_wr_addr <= word_idx;
        core_din     <= in_data;
      end
      if (accept && cnt_first) begin
        thread_q       <= in_thread_num;
        core_q         <= in_core;
        core_blk_op    <= in_blk_op;
        core_input_ctx <= in_ctx;
        core_input_seq <= in_seq;
      end
      if (accept && !cnt_first && (in_thread_num != thread_q)) err_thread <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_input_dist.sv
// Directed bench for core_input_dist: default instance plus a 5-core, 8-word,
// 32-bit instance.
module tb_core_input_dist;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  // Default instance
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_thread_num;
  logic [2:0]  in_blk_op, core_ready, core_wr_en, core_blk_done, core_blk_op;
  logic [3:0]  core_wr_addr;
  logic [63:0] core_din;
  logic        core_input_ctx, core_input_seq, err_thread;

  core_input_dist dut (
    .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_thread_num(in_thread_num), .in_blk_op(in_blk_op),
    .core_ready(core_ready), .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr),
    .core_din(core_din), .core_blk_op(core_blk_op), .core_input_ctx(core_input_ctx),
    .core_input_seq(core_input_seq), .core_blk_done(core_blk_done), .err_thread(err_thread)
  );

  // 5-core instance
  logic        v5, rdy5, ctx5, seq5, err5;
  logic [31:0] data5, din5;
  logic [4:0]  thr5, crdy5, wen5, done5;
  logic [2:0]  op5, addr5, bop5;

  core_input_dist #(.N_CORES(5), .WORDS_PER_BLK(8), .DATA_WIDTH(32)) dut5 (
    .CLK(CLK), .RESET_N(RESET_N), .in_valid(v5), .in_ready(rdy5),
    .in_data(data5), .in_thread_num(thr5), .in_blk_op(op5),
    .core_ready(crdy5), .core_wr_en(wen5), .core_wr_addr(addr5),
    .core_din(din5), .core_blk_op(bop5), .core_input_ctx(ctx5),
    .core_input_seq(seq5), .core_blk_done(done5), .err_thread(err5)
  );

  typedef struct {
    logic        vld;
    logic [3:0]  thr;
    logic [2:0]  op;
    logic [63:0] data;
    logic [2:0]  crdy;
    logic        e_rdy;
    logic [2:0]  e_wen;
    logic [3:0]  e_addr;
    logic [63:0] e_din;
    logic [2:0]  e_done;
    logic [2:0]  e_op;
    logic        e_ctx;
    logic        e_seq;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [2:0] cur_op;
  logic       cur_ctx, cur_seq;

  localparam logic [63:0] DA = 64'hA5A5_0000_0000_0000;
  localparam logic [63:0] DB = 64'hB0B0_0000_0000_0100;
  localparam logic [63:0] DC = 64'hC3C3_0000_0000_0200;
  localparam logic [63:0] DD = 64'hD0D0_0000_0000_0300;
  localparam logic [63:0] DE = 64'hE1E1_0000_0000_0400;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [3:0] thr, input logic [2:0] op,
                     input logic [63:0] data, input logic [2:0] crdy, input logic e_rdy,
                     input logic [2:0] e_wen, input logic [3:0] e_addr,
                     input logic [63:0] e_din, input logic [2:0] e_done);
    vec_t v;
    v.vld = vld; v.thr = thr; v.op = op; v.data = data; v.crdy = crdy;
    v.e_rdy = e_rdy; v.e_wen = e_wen; v.e_addr = e_addr; v.e_din = e_din;
    v.e_done = e_done; v.e_op = cur_op; v.e_ctx = cur_ctx; v.e_seq = cur_seq;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic vld, input logic [3:0] thr, input logic [2:0] op,
                       input logic [63:0] data, input logic [2:0] crdy);
    in_valid = vld; in_thread_num = thr; in_blk_op = op; in_data = data; core_ready = crdy;
  endtask

  initial begin
    RESET_N = 1'b0;
    drive(1'b0, 4'h0, 3'd0, 64'h0, 3'b111);
    v5 = 1'b0; thr5 = '0; op5 = '0; data5 = '0; crdy5 = '0;

    // ---- vector table ----
    cur_op = 3'd0; cur_ctx = 1'b0; cur_seq = 1'b0;
    // single block to core 2, ctx 1, seq 0, op 5
    for (int k = 0; k < 16; k++) begin
      if (k == 1) begin cur_op = 3'd5; cur_ctx = 1'b1; cur_seq = 1'b0; end
      add(1'b1, 4'b1010, 3'd5, DA + 64'(k), 3'b111, 1'b1,
          (k == 0) ? 3'b000 : 3'b100, 4'(k - 1), DA + 64'(k) - 64'd1, 3'b000);
    end
    add(1'b0, 4'b1010, 3'd5, 64'h0, 3'b111, 1'b1, 3'b100, 4'd15, DA + 64'd15, 3'b000);
    add(1'b0, 4'b1010, 3'd5, 64'h0, 3'b111, 1'b1, 3'b000, 4'd0, 64'h0, 3'b100);
    add(1'b0, 4'b1010, 3'd5, 64'h0, 3'b111, 1'b1, 3'b000, 4'd0, 64'h0, 3'b000);
    // readiness gating on core 1, then the block with core_ready low throughout
    for (int k = 0; k < 5; k++)
      add(1'b1, 4'b0100, 3'd3, DB, 3'b000, 1'b0, 3'b000, 4'd0, 64'h0, 3'b000);
    add(1'b1, 4'b0100, 3'd3, DB, 3'b010, 1'b1, 3'b000, 4'd0, 64'h0, 3'b000);
    for (int k = 1; k < 16; k++) begin
      if (k == 1) begin cur_op = 3'd3; cur_ctx = 1'b0; cur_seq = 1'b0; end
      add(1'b1, 4'b0100, 3'd3, DB + 64'(k), 3'b000, 1'b1, 3'b010, 4'(k - 1),
          DB + 64'(k) - 64'd1, 3'b000);
    end
    add(1'b0, 4'b0100, 3'd3, 64'h0, 3'b000, 1'b0, 3'b010, 4'd15, DB + 64'd15, 3'b000);
    add(1'b0, 4'b0100, 3'd3, 64'h0, 3'b000, 1'b0, 3'b000, 4'd0, 64'h0, 3'b010);
    add(1'b0, 4'b0100, 3'd3, 64'h0, 3'b000, 1'b0, 3'b000, 4'd0, 64'h0, 3'b000);
    // back-to-back: core 0 (ctx0 seq1 op2) then core 1 (ctx1 seq1 op6)
    for (int j = 0; j < 32; j++) begin
      if (j == 1)  begin cur_op = 3'd2; cur_ctx = 1'b0; cur_seq = 1'b1; end
      if (j == 17) begin cur_op = 3'd6; cur_ctx = 1'b1; cur_seq = 1'b1; end
      add(1'b1, (j < 16) ? 4'b0001 : 4'b0111, (j < 16) ? 3'd2 : 3'd6, DC + 64'(j),
          3'b011, 1'b1, (j == 0) ? 3'b000 : ((j <= 16) ? 3'b001 : 3'b010),
          4'(j - 1), DC + 64'(j) - 64'd1, (j == 17) ? 3'b001 : 3'b000);
    end
    add(1'b0, 4'b0111, 3'd6, 64'h0, 3'b011, 1'b1, 3'b010, 4'd15, DC + 64'd31, 3'b000);
    add(1'b0, 4'b0111, 3'd6, 64'h0, 3'b011, 1'b1, 3'b000, 4'd0, 64'h0, 3'b010);
    add(1'b0, 4'b0111, 3'd6, 64'h0, 3'b011, 1'b1, 3'b000, 4'd0, 64'h0, 3'b000);

    // ---- reset state ----
    #1;
    check("rst_rdy", 64'(in_ready), 64'd0);
    check("rst_wen", 64'(core_wr_en), 64'd0);
    check("rst_addr", 64'(core_wr_addr), 64'd0);
    check("rst_din", core_din, 64'd0);
    check("rst_done", 64'(core_blk_done), 64'd0);
    check("rst_op", 64'(core_blk_op), 64'd0);
    check("rst_ctx_seq", 64'({core_input_ctx, core_input_seq}), 64'd0);
    check("rst_err", 64'(err_thread), 64'd0);
    check("rst5_rdy_wen", 64'({rdy5, wen5, done5}), 64'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    // ---- apply table ----
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      drive(tbl[i].vld, tbl[i].thr, tbl[i].op, tbl[i].data, tbl[i].crdy);
      #1;
      check($sformatf("v%0d_rdy", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      check($sformatf("v%0d_wen", i), 64'(core_wr_en), 64'(tbl[i].e_wen));
      check($sformatf("v%0d_done", i), 64'(core_blk_done), 64'(tbl[i].e_done));
      check($sformatf("v%0d_op", i), 64'(core_blk_op), 64'(tbl[i].e_op));
      check($sformatf("v%0d_ctx", i), 64'(core_input_ctx), 64'(tbl[i].e_ctx));
      check($sformatf("v%0d_seq", i), 64'(core_input_seq), 64'(tbl[i].e_seq));
      check($sformatf("v%0d_err", i), 64'(err_thread), 64'd0);
      if (tbl[i].e_wen != 3'b000) begin
        check($sformatf("v%0d_addr", i), 64'(core_wr_addr), 64'(tbl[i].e_addr));
        check($sformatf("v%0d_din", i), core_din, tbl[i].e_din);
      end
    end

    // ---- thread number changes at word 7 ----
    for (int k = 0; k <= 16; k++) begin
      @(negedge CLK);
      drive(k < 16, (k < 7) ? 4'b1000 : 4'b0110, (k < 7) ? 3'd1 : 3'd7, DD + 64'(k), 3'b111);
      #1;
      if (k >= 1) begin
        check($sformatf("chg%0d_wen", k), 64'(core_wr_en), 64'b100);
        check($sformatf("chg%0d_addr", k), 64'(core_wr_addr), 64'(k - 1));
      end
      check($sformatf("chg%0d_err", k), 64'(err_thread), 64'(k >= 8));
    end
    @(negedge CLK);
    in_valid = 1'b0;
    #1;
    check("chg_done", 64'(core_blk_done), 64'b100);
    check("chg_err_sticky", 64'(err_thread), 64'd1);
    check("chg_op_kept", 64'(core_blk_op), 64'd1);
    check("chg_ctx_kept", 64'(core_input_ctx), 64'd0);

    // ---- reset asserted after word 9 is accepted ----
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      drive(1'b1, 4'b0000, 3'd4, DE + 64'(k), 3'b111);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    RESET_N  = 1'b0;
    #1;
    check("mrst_wen", 64'(core_wr_en), 64'd0);
    check("mrst_addr_din", core_din | 64'(core_wr_addr), 64'd0);
    check("mrst_fields", 64'({core_blk_op, core_input_ctx, core_input_seq}), 64'd0);
    check("mrst_err", 64'(err_thread), 64'd0);
    check("mrst_rdy", 64'(in_ready), 64'd0);
    @(negedge CLK);
    check("mrst_done", 64'(core_blk_done), 64'd0);
    RESET_N = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      drive(k < 16, 4'b0000, 3'd4, DE + 64'h100 + 64'(k), 3'b111);
      #1;
      check($sformatf("post%0d_wen", k), 64'(core_wr_en), (k >= 1) ? 64'b001 : 64'd0);
      if (k >= 1) check($sformatf("post%0d_addr", k), 64'(core_wr_addr), 64'(k - 1));
      check($sformatf("post%0d_done", k), 64'(core_blk_done), 64'd0);
      @(negedge CLK);
    end
    in_valid = 1'b0;
    #1;
    check("post_done", 64'(core_blk_done), 64'b001);

    // ---- 5 cores, 8 words, 32-bit data ----
    crdy5 = 5'b11111;
    for (int c = 4; c < 8; c++) begin
      thr5 = {3'(c), 2'b10};
      #1;
      check($sformatf("p5_rdy_core%0d", c), 64'(rdy5), 64'(c == 4));
    end
    for (int k = 0; k <= 8; k++) begin
      @(negedge CLK);
      v5 = (k < 8); thr5 = 5'b10010; op5 = 3'd7; data5 = 32'hC0DE_0000 + 32'(k);
      #1;
      check($sformatf("p5_%0d_wen", k), 64'(wen5), (k >= 1) ? 64'b10000 : 64'd0);
      if (k >= 1) begin
        check($sformatf("p5_%0d_addr", k), 64'(addr5), 64'(k - 1));
        check($sformatf("p5_%0d_din", k), 64'(din5), 64'(32'hC0DE_0000 + 32'(k - 1)));
      end
      check($sformatf("p5_%0d_done", k), 64'(done5), 64'd0);
    end
    @(negedge CLK);
    v5 = 1'b0;
    #1;
    check("p5_done", 64'(done5), 64'b10000);
    check("p5_fields", 64'({bop5, ctx5, seq5}), 64'({3'd7, 1'b1, 1'b0}));
    @(negedge CLK);
    #1;
    check("p5_done_clr", 64'(done5), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_input_dist.md
Name: core_input_dist

Overview:
- Parametrised successor to the single-cycle core input stage in the sha512crypt engine.
- Sits between the realign unit and the N_CORES SHA-512 cores. Takes a stream of block words tagged with a thread number, holds each block to one target core and writes it with per-core write enables.
- Generalised over core count, contexts per core, sequences per context, block length and data width.
- Adds flow control: a valid/ready handshake toward realign, per-core readiness gating, a protocol-error flag and a per-core one-hot completion pulse.

Parameters:
- N_CORES, 3, number of cores fed; ≥1.
- N_CTX, 2, contexts per core; power of 2, ≥2.
- N_SEQ, 2, sequences per context; power of 2, ≥2.
- WORDS_PER_BLK, 16, words per block; power of 2, ≥2.
- DATA_WIDTH, 64, word width.
- BLK_OP_WIDTH, 3, width of the block-operation field.
- Derived, in the package: CORE_W = max(1, clog2(N_CORES)); CTX_W = clog2(N_CTX); SEQ_W = clog2(N_SEQ); THREAD_W = CORE_W+CTX_W+SEQ_W; ADDR_W = clog2(WORDS_PER_BLK).

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- in_valid  in  1  word available from realign.
- in_ready  out  1  this block accepts the word this cycle.
- in_data  in  DATA_WIDTH  word payload.
- in_thread_num  in  THREAD_W  thread number, packed as {core, ctx, seq} with seq in the LSBs.
- in_blk_op  in  BLK_OP_WIDTH  block operation; sampled on the first word of a block.
- core_ready  in  N_CORES  target core can take a new block.
- core_wr_en  out  N_CORES  one-hot write strobe.
- core_wr_addr  out  ADDR_W  word index inside the block.
- core_din  out  DATA_WIDTH  word data.
- core_blk_op  out  BLK_OP_WIDTH  block op of the current block.
- core_input_ctx  out  CTX_W  context of the current block.
- core_input_seq  out  SEQ_W  sequence of the current block.
- core_blk_done  out  N_CORES  one-hot, 1-cycle pulse after the last word is written.
- err_thread  out  1  sticky: thread number changed mid-block.

Behaviour:
- Reset (asynchronous, RESET_N=0): all outputs are 0, FSM is IDLE, word counter is 0, err_thread is 0.
  - Asserting reset mid-block drops the partial block. No done pulse is issued.
- Accept condition: a word is accepted when in_valid & in_ready.
- FSM state IDLE:
  - in_ready = core_ready[core field of in_thread_num].
  - A core field ≥ N_CORES forces in_ready=0.
  - On accept, latch thread number, core, ctx, seq and in_blk_op, then go to LOAD.
- FSM state LOAD:
  - in_ready = 1; core_ready is ignored until the block ends.
  - The word counter increments on each accept.
  - The accept of word index WORDS_PER_BLK-1 returns the FSM to IDLE and wraps the counter to 0.
- Write latency, 1 cycle: a word accepted in cycle t gives, in cycle t+1:
  - core_wr_en[latched core]=1, all other bits 0;
  - core_wr_addr = word index;
  - core_din = word.
- Block fields: core_blk_op, core_input_ctx and core_input_seq update in the first-word write cycle and hold until the next block's first write.
- Completion: the last write is in cycle t+1; core_blk_done[core] pulses in t+2 for exactly one cycle.
- Back-to-back blocks: IDLE accepts the next first word in the same cycle as that last write (t+1). No bubble is required.
- Mid-block thread change: an accepted word in LOAD whose in_thread_num differs from the latched value:
  - sets err_thread, which is cleared only by reset;
  - is still written to the latched core;
  - has its in_blk_op ignored.
- Idle cycles: with in_valid=0, core_wr_en=0 and the counter holds. A block may be interrupted by gaps.
- Width rules:
  - The counter is exactly ADDR_W bits and wraps naturally.
  - With N_CORES=1, the core field is 1 bit and must be 0.

Decomposition:
- Package sha512_dist_pkg holds the derived widths, the thread-field extract functions (core_of, ctx_of, seq_of) and the FSM state enum.
- One natural sub-module: blk_word_counter, an ADDR_W counter with first/last flags.
- The FSM, one-hot decode and output registers stay in core_input_dist.

Test Plan:
- Single block, defaults, all core_ready=1: 16 words, thread {core=2, ctx=1, seq=0}, blk_op=5.
  - core_wr_en=3'b100 on 16 consecutive cycles with addr 0..15.
  - core_input_ctx=1, core_input_seq=0, core_blk_op=5.
  - core_blk_done=3'b100 one cycle after addr 15.
- Readiness gating: core_ready=3'b000, in_valid=1 to core 1 for 5 cycles → in_ready=0 and no writes. Raise core_ready[1] → first write 1 cycle later.
- Back-to-back: block to core 0, then core 1 with no gap → 32 continuous writes. Done pulses at 3'b001 then 3'b010, each 1 cycle.
- Mid-block change: the thread number changes at word 7 → err_thread=1 from the next cycle and stays set; all 16 words still go to the original core.
- Reset at word 9: pull RESET_N low → outputs 0 immediately and no done pulse. After release, a new block starts at addr 0.
- Parametrised run with N_CORES=5, WORDS_PER_BLK=8, DATA_WIDTH=32: a block to core 4 → addr 0..7, core_wr_en=5'b10000, done after addr 7. Core field 5..7 → in_ready=0.
